// File: rtl/arb_pkg.sv
// arb_pkg - shared constants and types for the 8-way round-robin bus arbiter.
//   NREQ        number of requesters
//   IDXW        width of a requester index / priority pointer
//   arb_state_t ownership FSM states
//   onehot()    index -> one-hot grant vector
package arb_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8 - combinational round-robin picker.
// Finds the first set request bit at or above ptr, wrapping 7 -> 0.
//   req   in  NREQ  requests, already masked by the caller
//   ptr   in  IDXW  highest-priority index
//   found out 1     any request set
//   idx   out IDXW  winning index (== ptr when nothing is found)
module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] idx
);

  logic [IDXW-1:0] cand;

  // Walk the ring starting at ptr; the IDXW-bit add wraps for free.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IDXW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_bus_arbiter8.sv
// rr_bus_arbiter8 - round-robin owner arbiter for a shared 32-bit 8:1 mux.
// One requester owns the bus until it drops req; ownership changes always
// pass through one IDLE cycle with gnt=0. sel is the mux select {C2,C1,C0}
// and only changes on the edge that asserts a new grant.
//
// Optional feature: define RRARB_HOLD_LIMIT_EN to bound ownership to
// MAX_HOLD cycles. A revoked requester is masked until it drops req.
//
//   MAX_HOLD  param  ownership limit (2..255), hold-limit build only
//   clk       in  1  rising-edge clock
//   reset_n   in  1  async active-low reset
//   req       in  8  level requests
//   gnt       out 8  one-hot grant, zero when idle
//   sel       out 3  current/last owner index
//   busy      out 1  any grant active
//   forced    out 1  one-cycle pulse on hold-limit revoke (0 otherwise)
module rr_bus_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDXW-1:0] sel,
  output logic            busy,
  output logic            forced
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_bus_arbiter8: MAX_HOLD must be in 2..255");
  end

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0] sel_q, sel_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] req_eff;
  logic            pick_found;
  logic [IDXW-1:0] pick_idx;

`ifdef RRARB_HOLD_LIMIT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0]      cnt_q, cnt_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic            forced_q, forced_d;

  assign req_eff = req & ~mask_q;
`else
  assign req_eff = req;
`endif

  rr_pick8 u_pick (
    .req   (req_eff),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
`ifdef RRARB_HOLD_LIMIT_EN
    cnt_d    = cnt_q;
    forced_d = 1'b0;
    // A mask bit lives only while its request stays high.
    mask_d   = mask_q & req;
`endif
    case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d = OWN;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
`ifdef RRARB_HOLD_LIMIT_EN
          cnt_d   = '0;
`endif
        end
      end
      OWN: begin
        // Voluntary release wins over the hold limit on the same edge.
        if (!req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = sel_q + IDXW'(1);
        end
`ifdef RRARB_HOLD_LIMIT_EN
        else if (cnt_q == HOLD_LAST) begin
          state_d       = IDLE;
          gnt_d         = '0;
          ptr_d         = sel_q + IDXW'(1);
          forced_d      = 1'b1;
          mask_d[sel_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

`ifdef RRARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      mask_q   <= '0;
      forced_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      mask_q   <= mask_d;
      forced_q <= forced_d;
    end
  end

  assign forced = forced_q;
`else
  assign forced = 1'b0;
`endif

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = |gnt_q;

endmodule

// File: tb/tb_rr_bus_arbiter8.sv
// tb_rr_bus_arbiter8 - directed, table-driven bench for rr_bus_arbiter8.
// Built with MAX_HOLD=4; the hold-limit sequence runs only when
// RRARB_HOLD_LIMIT_EN is defined, otherwise unbounded ownership is checked.
module tb_rr_bus_arbiter8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       busy;
  logic       forced;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_bus_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .busy    (busy),
    .forced  (forced)
  );

  typedef struct {
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
  } vec_t;

  task automatic chk(input string name, input logic [7:0] eg, input logic [2:0] es,
                     input logic eb, input logic ef);
    n_checks++;
    if (gnt !== eg || sel !== es || busy !== eb || forced !== ef) begin
      n_fail++;
      $display("FAIL %s: got gnt=%h sel=%0d busy=%b forced=%b, want gnt=%h sel=%0d busy=%b forced=%b",
               name, gnt, sel, busy, forced, eg, es, eb, ef);
    end
  endtask

  // Drive req away from the rising edge, then sample just after it.
  task automatic step(input logic [7:0] r);
    @(negedge clk);
    req = r;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("reset_pulse", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  vec_t vecs[24];

  initial begin
    vecs[0]  = '{8'h04, 8'h04, 3'd2, 1'b1}; // single requester
    vecs[1]  = '{8'h04, 8'h04, 3'd2, 1'b1};
    vecs[2]  = '{8'h00, 8'h00, 3'd2, 1'b0}; // release -> ptr=3, sel kept
    vecs[3]  = '{8'h00, 8'h00, 3'd2, 1'b0};
    vecs[4]  = '{8'h05, 8'h01, 3'd0, 1'b1}; // ptr=3: 0 beats 2 via wrap
    vecs[5]  = '{8'h04, 8'h00, 3'd0, 1'b0};
    vecs[6]  = '{8'h04, 8'h04, 3'd2, 1'b1};
    vecs[7]  = '{8'h00, 8'h00, 3'd2, 1'b0};
    vecs[8]  = '{8'h20, 8'h20, 3'd5, 1'b1}; // no preemption
    vecs[9]  = '{8'h21, 8'h20, 3'd5, 1'b1};
    vecs[10] = '{8'h21, 8'h20, 3'd5, 1'b1};
    vecs[11] = '{8'h01, 8'h00, 3'd5, 1'b0};
    vecs[12] = '{8'h01, 8'h01, 3'd0, 1'b1};
    vecs[13] = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[14] = '{8'h40, 8'h40, 3'd6, 1'b1}; // set up ptr=7
    vecs[15] = '{8'h00, 8'h00, 3'd6, 1'b0};
    vecs[16] = '{8'h81, 8'h80, 3'd7, 1'b1}; // wrap: 7 first
    vecs[17] = '{8'h01, 8'h00, 3'd7, 1'b0};
    vecs[18] = '{8'h01, 8'h01, 3'd0, 1'b1}; // then 0
    vecs[19] = '{8'h00, 8'h00, 3'd0, 1'b0};
    vecs[20] = '{8'h0C, 8'h04, 3'd2, 1'b1}; // 3 waits behind 2
    vecs[21] = '{8'h04, 8'h04, 3'd2, 1'b1}; // 3 drops: not stored
    vecs[22] = '{8'h00, 8'h00, 3'd2, 1'b0};
    vecs[23] = '{8'h00, 8'h00, 3'd2, 1'b0};

    // Reset state and reset mid-ownership.
    #1;
    chk("reset_init", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    step(8'h10);
    chk("own4", 8'h10, 3'd4, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("reset_mid_own", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("regrant_after_reset", 8'h10, 3'd4, 1'b1, 1'b0);
    step(8'h00);
    chk("release4", 8'h00, 3'd4, 1'b0, 1'b0);

    // Vector table.
    for (int i = 0; i < 24; i++) begin
      step(vecs[i].req);
      chk($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel, vecs[i].busy, 1'b0);
    end

    // Fairness from ptr=0 with all requesters active.
    pulse_reset();
    for (int k = 0; k < 9; k++) begin
      logic [7:0] b;
      b = 8'h01 << (k % 8);
      step(8'hFF);
      chk($sformatf("fair_grant%0d", k), b, 3'(k % 8), 1'b1, 1'b0);
      step(8'hFF & ~b);
      chk($sformatf("fair_dead%0d", k), 8'h00, 3'(k % 8), 1'b0, 1'b0);
    end
    // ptr is now 1.

`ifdef RRARB_HOLD_LIMIT_EN
    for (int c = 0; c < 4; c++) begin
      step(8'h0A);
      chk($sformatf("hold_own%0d", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    step(8'h0A);
    chk("hold_forced", 8'h00, 3'd1, 1'b0, 1'b1);
    step(8'h0A);
    chk("hold_next3", 8'h08, 3'd3, 1'b1, 1'b0);
    step(8'h02);
    chk("hold_rel3", 8'h00, 3'd3, 1'b0, 1'b0);
    step(8'h02);
    chk("hold_masked", 8'h00, 3'd3, 1'b0, 1'b0);
    step(8'h00);
    chk("hold_unmask", 8'h00, 3'd3, 1'b0, 1'b0);
    step(8'h02);
    chk("hold_regrant1", 8'h02, 3'd1, 1'b1, 1'b0);
    step(8'h00);
    chk("hold_final_rel", 8'h00, 3'd1, 1'b0, 1'b0);
`else
    for (int c = 0; c < 7; c++) begin
      step(8'h0A);
      chk($sformatf("unbounded_own%0d", c), 8'h02, 3'd1, 1'b1, 1'b0);
    end
    step(8'h08);
    chk("unbounded_rel", 8'h00, 3'd1, 1'b0, 1'b0);
    step(8'h08);
    chk("unbounded_next3", 8'h08, 3'd3, 1'b1, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
